mtr_drv: RTL and testbench

MTR_DRV -- requirements
Module: mtr_drv

---
 rtl/mtr_drv_if.sv | 27 ++
 rtl/mtr_drv.sv | 81 ++++++++
 tb/tb_mtr_drv.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mtr_drv_if.sv
// Motor drive bus: signed speed commands in, H-bridge gate drives out.
interface mtr_drv_if;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        lftPWM1;
  logic        lftPWM2;
  logic        rghtPWM1;
  logic        rghtPWM2;

  modport slave (
    input  lft_spd,
    input  rght_spd,
    output lftPWM1,
    output lftPWM2,
    output rghtPWM1,
    output rghtPWM2
  );

  modport master (
    output lft_spd,
    output rght_spd,
    input  lftPWM1,
    input  lftPWM2,
    input  rghtPWM1,
    input  rghtPWM2
  );
endinterface

// File: rtl/mtr_drv.sv
// Dual-channel H-bridge PWM generator with per-channel dead-time insertion.
// Optional macro MTR_DRV_SPD_SAT_EN clamps speeds to +/-960 before duty mapping.
module mtr_drv #(
  parameter logic [10:0] NONOVERLAP = 11'h020
) (
  input logic        clk,
  input logic        rst_n,
  mtr_drv_if.slave   bus
);

  localparam int unsigned CW    = 11;
  localparam int unsigned NCH   = 2;
  localparam logic [CW-1:0] CNT_LAST   = 11'h7FF;
  localparam logic [CW-1:0] DUTY_RESET = 11'h400;

  logic [CW-1:0]           cnt;
  logic [NCH-1:0][CW-1:0]  spd;
  logic [NCH-1:0][CW-1:0]  duty_q;
  logic [NCH-1:0][CW-1:0]  dt_q;
  logic [NCH-1:0]          sig_q;
  logic [NCH-1:0]          sig_d;
  logic [NCH-1:0]          chg_c;
  logic [NCH-1:0]          pwm1_q;
  logic [NCH-1:0]          pwm2_q;

  // Speed to duty: offset-binary conversion, optionally after clamping.
  function automatic logic [CW-1:0] to_duty(input logic [CW-1:0] s);
    logic [CW-1:0] c;
    c = s;
`ifdef MTR_DRV_SPD_SAT_EN
    if ($signed(s) > $signed(11'h3C0))
      c = 11'h3C0;
    else if ($signed(s) < $signed(11'h440))
      c = 11'h440;
`endif
    return {~c[CW-1], c[CW-2:0]};
  endfunction

  assign spd[0] = bus.lft_spd;
  assign spd[1] = bus.rght_spd;

  always_comb begin
    sig_d = '0;
    chg_c = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      sig_d[ch] = (cnt < duty_q[ch]);
      chg_c[ch] = sig_d[ch] ^ sig_q[ch];
    end
  end

  // Outputs follow sig only once it has been stable for NONOVERLAP cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      duty_q <= {NCH{DUTY_RESET}};
      sig_q  <= '0;
      dt_q   <= '0;
      pwm1_q <= '0;
      pwm2_q <= '0;
    end else begin
      cnt <= cnt + CW'(1);
      for (int ch = 0; ch < NCH; ch++) begin
        if (cnt == CNT_LAST)
          duty_q[ch] <= to_duty(spd[ch]);
        sig_q[ch] <= sig_d[ch];
        if (chg_c[ch])
          dt_q[ch] <= '0;
        else if (dt_q[ch] < NONOVERLAP)
          dt_q[ch] <= dt_q[ch] + CW'(1);
        pwm1_q[ch] <= (dt_q[ch] >= NONOVERLAP) &  sig_q[ch];
        pwm2_q[ch] <= (dt_q[ch] >= NONOVERLAP) & ~sig_q[ch];
      end
    end
  end

  assign bus.lftPWM1  = pwm1_q[0];
  assign bus.lftPWM2  = pwm2_q[0];
  assign bus.rghtPWM1 = pwm1_q[1];
  assign bus.rghtPWM2 = pwm2_q[1];

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: a sig-history window model predicts every output cycle.
module tb_mtr_drv;
  localparam int N = 32;
  localparam int PER = 2048;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mtr_drv_if bus();

  mtr_drv #(.NONOVERLAP(11'(N))) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt;
  int m_duty [2];
  int hl[$];
  int hr[$];
  int hi [4];

  // Spec-level duty: signed speed (optionally clamped) plus 1024.
  function automatic int map_duty(input logic [10:0] spd);
    logic signed [10:0] ss;
    int s;
    ss = spd;
    s = int'(ss);
`ifdef MTR_DRV_SPD_SAT_EN
    if (s > 960) s = 960;
    if (s < -960) s = -960;
`endif
    return s + 1024;
  endfunction

  // Output pair is driven only if sig held one value over the whole window.
  function automatic logic [1:0] exp_pair(input int q[$]);
    bit all1, all0;
    all1 = 1'b1;
    all0 = 1'b1;
    foreach (q[i]) begin
      if (q[i] != 1) all1 = 1'b0;
      if (q[i] != 0) all0 = 1'b0;
    end
    return {all1, all0};
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_duty[0] = 1024;
    m_duty[1] = 1024;
    hl.delete();
    hr.delete();
    repeat (N + 1) begin
      hl.push_front(2);
      hr.push_front(2);
    end
  endtask

  task automatic clear_hi();
    for (int i = 0; i < 4; i++) hi[i] = 0;
  endtask

  task automatic step(input int n);
    logic [3:0] e, act;
    int sl, sr;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      e  = {exp_pair(hl), exp_pair(hr)};
      sl = (m_cnt < m_duty[0]) ? 1 : 0;
      sr = (m_cnt < m_duty[1]) ? 1 : 0;
      if (m_cnt == PER - 1) begin
        m_duty[0] = map_duty(bus.lft_spd);
        m_duty[1] = map_duty(bus.rght_spd);
      end
      m_cnt = (m_cnt + 1) % PER;
      hl.push_front(sl); void'(hl.pop_back());
      hr.push_front(sr); void'(hr.pop_back());
      #1;
      act = {bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1, bus.rghtPWM2};
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL pwm cnt=%0d: got %b expected %b", m_cnt, act, e);
      end
      n_cmp++;
      if ({bus.lftPWM1 & bus.lftPWM2, bus.rghtPWM1 & bus.rghtPWM2} !== 2'b00) begin
        n_bad++;
        $display("FAIL overlap cnt=%0d: got %b expected 0000 overlap-free", m_cnt, act);
      end
      hi[0] += int'(bus.lftPWM1);
      hi[1] += int'(bus.lftPWM2);
      hi[2] += int'(bus.rghtPWM1);
      hi[3] += int'(bus.rghtPWM2);
    end
  endtask

  task automatic step_until(input int c);
    for (int i = 0; i < 2 * PER && m_cnt != c; i++) step(1);
    if (m_cnt != c) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_cnt: got %0d expected %0d", m_cnt, c);
    end
  endtask

  task automatic first_rise(input string name);
    int k;
    k = -1;
    for (int i = 1; i <= 100 && k < 0; i++) begin
      step(1);
      if (bus.lftPWM1 === 1'b1) k = i;
    end
    n_cmp++;
    if (k !== N + 2) begin
      n_bad++;
      $display("FAIL %s: first edge at cycle %0d expected %0d", name, k, N + 2);
    end
  endtask

  task automatic check_counts(input string name, input int e0, input int e1,
                              input int e2, input int e3);
    int ex [4];
    ex = '{e0, e1, e2, e3};
    step(2 * PER);
    clear_hi();
    step(PER);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (hi[i] !== ex[i]) begin
        n_bad++;
        $display("FAIL %s out%0d: high %0d cycles expected %0d", name, i, hi[i], ex[i]);
      end
    end
  endtask

  task automatic set_spd(input logic [10:0] l, input logic [10:0] r);
    @(negedge clk);
    bus.lft_spd  = l;
    bus.rght_spd = r;
  endtask

  task automatic test_reset();
    logic [3:0] act;
    bus.lft_spd  = '0;
    bus.rght_spd = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    act = {bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1, bus.rghtPWM2};
    n_cmp++;
    if (act !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 0000", act);
    end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    first_rise("reset_first_edge");
  endtask

  task automatic test_zero_speed();
    set_spd(11'h000, 11'h000);
    check_counts("zero_speed", 992, 992, 992, 992);
  endtask

  task automatic test_fwd_512();
    set_spd(11'h200, 11'h000);
    check_counts("fwd_512", 1504, 480, 992, 992);
  endtask

  task automatic test_mid_change();
    set_spd(11'h000, 11'h000);
    step(2 * PER);
    step_until(700);
    set_spd(11'h600, 11'h000);
    step_until(0);
    check_counts("mid_change", 480, 1504, 992, 992);
  endtask

  task automatic test_full_reverse();
    set_spd(11'h400, 11'h000);
`ifdef MTR_DRV_SPD_SAT_EN
    check_counts("full_reverse", 32, 1952, 992, 992);
`else
    check_counts("full_reverse", 0, 2048, 992, 992);
`endif
  endtask

  task automatic test_random();
    int left;
    int chunk;
    left = 20000;
    while (left > 0) begin
      chunk = int'($urandom_range(1, 3000));
      if (chunk > left) chunk = left;
      set_spd(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)));
      step(chunk);
      left -= chunk;
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] act;
    set_spd(11'h200, 11'h000);
    step(2 * PER);
    step_until(1200);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    act = {bus.lftPWM1, bus.lftPWM2, bus.rghtPWM1, bus.rghtPWM2};
    n_cmp++;
    if (act !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %b expected 0000", act);
    end
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    first_rise("reset_mid_first_edge");
    step(PER);
  endtask

  initial begin
    test_reset();
    test_zero_speed();
    test_fwd_512();
    test_mid_change();
    test_full_reverse();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
